// File: rtl/fifo_level.sv
// Single-clock show-ahead FIFO with occupancy count and almost-full/almost-empty flags.
// Define FIFO_LEVEL_ERRFLAGS_EN to build the sticky OVERFLOW/UNDERFLOW flags.
module fifo_level #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_EXP   = 4,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic                  FLUSH,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  PUSH,
    input  logic                  POP,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [ADDR_EXP:0]     LEVEL,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);
    localparam int DEPTH = 2 ** ADDR_EXP;
    localparam int LW    = ADDR_EXP + 1;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_EXP-1:0]   r_rd_ptr;
    logic [ADDR_EXP-1:0]   r_wr_ptr;
    logic [LW-1:0]         r_level;

    logic w_clear;
    logic w_full;
    logic w_empty;
    logic w_accept_wr;
    logic w_accept_rd;

    // Flags come from the LEVEL register only, so PUSH/POP never reach them combinationally.
    assign w_full       = (r_level == DEPTH_L);
    assign w_empty      = (r_level == '0);
    assign w_clear      = RESET | ~ENABLE | FLUSH;
    assign w_accept_wr  = PUSH & (~w_full | POP);
    assign w_accept_rd  = POP & ~w_empty;

    assign FULL         = w_full;
    assign EMPTY        = w_empty;
    assign LEVEL        = r_level;
    assign ALMOST_FULL  = (r_level >= AF_L);
    assign ALMOST_EMPTY = (r_level <= AE_L);
    assign DATA_OUT     = w_empty ? '0 : r_mem[r_rd_ptr];

    // NOTE: storage has no reset; a clear only rewinds the pointers, and gating with
    // w_clear keeps a write issued alongside a clear from landing.
    always_ff @(posedge CLK) begin
        if (!w_clear && w_accept_wr) begin
            r_mem[r_wr_ptr] <= DATA_IN;
        end
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (w_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_accept_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_accept_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_accept_wr, w_accept_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef FIFO_LEVEL_ERRFLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge CLK) begin
        if (w_clear) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (PUSH && w_full && !POP) r_overflow  <= 1'b1;
            if (POP && w_empty)         r_underflow <= 1'b1;
        end
    end

    assign OVERFLOW  = r_overflow;
    assign UNDERFLOW = r_underflow;
`else
    assign OVERFLOW  = 1'b0;
    assign UNDERFLOW = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_level.sv
// Self-checking bench for fifo_level (depth 4, AF=3, AE=1) using a data scoreboard queue
// plus a reference occupancy/error-flag model; honours FIFO_LEVEL_ERRFLAGS_EN.
module tb_fifo_level;
    localparam int DW    = 8;
    localparam int AE    = 2;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          ENABLE = 1'b1;
    logic          FLUSH = 1'b0;
    logic [DW-1:0] DATA_IN = '0;
    logic          PUSH = 1'b0;
    logic          POP = 1'b0;
    logic [DW-1:0] DATA_OUT;
    logic          FULL;
    logic          EMPTY;
    logic [AE:0]   LEVEL;
    logic          ALMOST_FULL;
    logic          ALMOST_EMPTY;
    logic          OVERFLOW;
    logic          UNDERFLOW;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] sb[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    fifo_level #(.DATA_WIDTH(DW), .ADDR_EXP(AE), .AF_THRESH(3), .AE_THRESH(1)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .FLUSH(FLUSH),
        .DATA_IN(DATA_IN), .PUSH(PUSH), .POP(POP), .DATA_OUT(DATA_OUT),
        .FULL(FULL), .EMPTY(EMPTY), .LEVEL(LEVEL),
        .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
        .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    function automatic logic [8:0] exp_status();
        int lvl = sb.size();
        return {lvl == DEPTH, lvl == 0, 3'(lvl), lvl >= 3, lvl <= 1, m_ovf, m_unf};
    endfunction

    function automatic logic [8:0] dut_status();
        return {FULL, EMPTY, LEVEL, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW};
    endfunction

    function automatic logic [DW-1:0] exp_head();
        return (sb.size() == 0) ? '0 : sb[0];
    endfunction

    // Applies one cycle of stimulus from a negedge, updates the model, returns at the next negedge.
    task automatic drive(input logic push, input logic pop, input logic [DW-1:0] din,
                         input logic flush, input logic en, input logic rst);
        logic full_m, empty_m, wr, rd;
        logic [DW-1:0] dropped;
        PUSH = push; POP = pop; DATA_IN = din; FLUSH = flush; ENABLE = en; RESET = rst;
        if (rst || !en || flush) begin
            sb.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            full_m  = (sb.size() == DEPTH);
            empty_m = (sb.size() == 0);
            wr = push && (!full_m || pop);
            rd = pop && !empty_m;
`ifdef FIFO_LEVEL_ERRFLAGS_EN
            if (push && full_m && !pop) m_ovf = 1'b1;
            if (pop && empty_m)         m_unf = 1'b1;
`endif
            if (rd) dropped = sb.pop_front();
            if (wr) sb.push_back(din);
        end
        @(negedge CLK);
        PUSH = 1'b0; POP = 1'b0; FLUSH = 1'b0; ENABLE = 1'b1; RESET = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        total++;
        if (dut_status() !== 9'b0_1_000_0_1_0_0) begin
            bad++; $display("FAIL reset_status got=%b want=%b", dut_status(), 9'b0_1_000_0_1_0_0);
        end
        total++;
        if (DATA_OUT !== 8'h00) begin
            bad++; $display("FAIL reset_dout got=%h want=00", DATA_OUT);
        end
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, vals[i], 1'b0, 1'b1, 1'b0);
            total++;
            if (dut_status() !== exp_status() || LEVEL !== 3'(i + 1)) begin
                bad++; $display("FAIL fill_status[%0d] got=%b want=%b", i, dut_status(), exp_status());
            end
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (DATA_OUT !== exp_head() || DATA_OUT !== vals[i]) begin
                bad++; $display("FAIL drain_data[%0d] got=%h want=%h", i, DATA_OUT, vals[i]);
            end
            drive(1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b0);
            total++;
            if (dut_status() !== exp_status()) begin
                bad++; $display("FAIL drain_status[%0d] got=%b want=%b", i, dut_status(), exp_status());
            end
        end
        total++;
        if (EMPTY !== 1'b1 || DATA_OUT !== 8'h00) begin
            bad++; $display("FAIL drain_empty got=%b/%h want=1/00", EMPTY, DATA_OUT);
        end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'(8'hA0 + 16 * r + i), 1'b0, 1'b1, 1'b0);
            for (int i = 0; i < 3; i++) begin
                total++;
                if (DATA_OUT !== exp_head()) begin
                    bad++; $display("FAIL wrap_data[%0d.%0d] got=%h want=%h", r, i, DATA_OUT, exp_head());
                end
                drive(1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b0);
            end
        end
        total++;
        if (dut_status() !== exp_status() || LEVEL !== 3'd0) begin
            bad++; $display("FAIL wrap_level got=%b want=%b", dut_status(), exp_status());
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, 8'(i), 1'b0, 1'b1, 1'b0);
        total++;
        if (DATA_OUT !== 8'h01) begin
            bad++; $display("FAIL fpp_head got=%h want=01", DATA_OUT);
        end
        drive(1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        total++;
        if (dut_status() !== exp_status() || LEVEL !== 3'd4 || DATA_OUT !== 8'h02) begin
            bad++; $display("FAIL fpp_after got=%b/%h want=%b/02", dut_status(), DATA_OUT, exp_status());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (DATA_OUT !== exp_head()) begin
                bad++; $display("FAIL fpp_drain[%0d] got=%h want=%h", i, DATA_OUT, exp_head());
            end
            drive(1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_errors();
        for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'h66, 1'b0, 1'b1, 1'b0);
        total++;
        if (dut_status() !== exp_status()) begin
            bad++; $display("FAIL overflow got=%b want=%b", dut_status(), exp_status());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (DATA_OUT !== exp_head() || DATA_OUT === 8'h66) begin
                bad++; $display("FAIL ovf_drain[%0d] got=%h want=%h", i, DATA_OUT, exp_head());
            end
            drive(1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b0);
        end
        drive(1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b0);
        total++;
        if (dut_status() !== exp_status()) begin
            bad++; $display("FAIL underflow got=%b want=%b", dut_status(), exp_status());
        end
        // Push+pop while empty: pop ignored, word stored.
        drive(1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
        total++;
        if (dut_status() !== exp_status() || DATA_OUT !== 8'h5A) begin
            bad++; $display("FAIL empty_pp got=%b/%h want=%b/5a", dut_status(), DATA_OUT, exp_status());
        end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        total++;
        if (dut_status() !== 9'b0_1_000_0_1_0_0) begin
            bad++; $display("FAIL err_flush got=%b want=%b", dut_status(), 9'b0_1_000_0_1_0_0);
        end
    endtask

    task automatic test_flush_enable();
        drive(1'b1, 1'b0, 8'h71, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'h72, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'h77, 1'b1, 1'b1, 1'b0);
        total++;
        if (dut_status() !== exp_status() || LEVEL !== 3'd0 || DATA_OUT !== 8'h00) begin
            bad++; $display("FAIL flush_push got=%b/%h want=%b/00", dut_status(), DATA_OUT, exp_status());
        end
        drive(1'b1, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'h82, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'h83, 1'b0, 1'b0, 1'b0);
        total++;
        if (dut_status() !== exp_status() || LEVEL !== 3'd0 || DATA_OUT !== 8'h00) begin
            bad++; $display("FAIL enable_low got=%b/%h want=%b/00", dut_status(), DATA_OUT, exp_status());
        end
        drive(1'b1, 1'b0, 8'h84, 1'b0, 1'b1, 1'b0);
        total++;
        if (DATA_OUT !== 8'h84 || LEVEL !== 3'd1) begin
            bad++; $display("FAIL after_enable got=%h/%0d want=84/1", DATA_OUT, LEVEL);
        end
    endtask

    task automatic test_back_to_back();
        logic p, q;
        for (int n = 0; n < 300; n++) begin
            p = 1'($urandom_range(0, 1));
            q = 1'($urandom_range(0, 1));
            total++;
            if (DATA_OUT !== exp_head()) begin
                bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", n, DATA_OUT, exp_head());
            end
            drive(p, q, 8'($urandom), (n % 97) == 96, 1'b1, (n % 151) == 150);
            total++;
            if (dut_status() !== exp_status()) begin
                bad++; $display("FAIL b2b_status[%0d] got=%b want=%b", n, dut_status(), exp_status());
            end
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_push_pop();
        test_errors();
        test_flush_enable();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
